alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Two-requester arbiter and sequencer for the shared 32-bit combinational ALU (operands a, b; 4-bit aluc; result r; flags zero/carry/negative/overflow).
- Accepts one operation per cycle from either requester via valid/ready, using round-robin arbitration.
- Drives the ALU operand bus from the granted requester.
- Captures r and the flags into a single output register, tagged with the source ID, behind a valid/ready handshake with backpressure.

Parameters:
- DW, 32, operand/result width.
- CW, 4, aluc width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  DW  requester 0 operand a.
- req0_b  in  DW  requester 0 operand b.
- req0_aluc  in  CW  requester 0 opcode.
- req1_valid / req1_ready / req1_a / req1_b / req1_aluc: same as requester 0, for requester 1.
- alu_a  out  DW  to ALU a.
- alu_b  out  DW  to ALU b.
- alu_aluc  out  CW  to ALU aluc.
- alu_r  in  DW  from ALU r.
- alu_zero, alu_carry, alu_negative, alu_overflow  in  1 each  ALU flags.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer takes result.
- out_r  out  DW  registered result.
- out_flags  out  4  {overflow, negative, carry, zero}, registered.
- out_src  out  1  requester ID of the result.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_r=0, out_flags=0, out_src=0.
  - last_grant=1, so requester 0 wins the first tie.
  - req*_ready=0 while in reset.
- Two states, encoded by out_valid:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_accept = !out_valid | out_ready. Accept is combinational, same cycle.
- Grant, evaluated only when can_accept:
  - Only one reqN_valid high: grant it.
  - Both high: grant the requester != last_grant.
  - Neither high: no grant.
- reqN_ready = grant_N. Ready is never high for both requesters, and never high while FULL with out_ready=0.
- Granted transfer (reqN_valid & reqN_ready):
  - alu_a/alu_b/alu_aluc = reqN_a/b/aluc combinationally in that cycle.
  - At the clock edge: out_r<=alu_r, out_flags<=ALU flags, out_src<=N, out_valid<=1, last_grant<=N.
- No grant: alu_a=0, alu_b=0, alu_aluc=0, so the ALU bus is deterministic.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 op/cycle when out_ready stays high.
- FULL & out_ready=0:
  - out_* held stable bit-for-bit.
  - Both req*_ready=0.
  - Requester inputs ignored.
- FULL & out_ready=1:
  - With a grant the same cycle: register reloads, out_valid stays 1.
  - Without a grant: out_valid<=0. out_r/out_flags/out_src keep their old values (don't-care while invalid).
- Requester may drop valid before ready; no state change results.
- Fairness: under continuous dual requests, grants strictly alternate 0,1,0,1...
- last_grant changes only on an actual transfer.
- Reset mid-operation: a pending result is discarded, out_valid=0 immediately (asynchronously), and arbitration restarts at requester 0.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined:
  - Requester 0 always wins ties.
  - last_grant register removed.
  - Requester 1 is granted only when req0_valid=0.
- Undefined (default): round-robin as above.
- Handshake, latency and output behaviour are identical in both builds.

Decomposition:
- Package alu_arb_pkg:
  - DW/CW defaults.
  - Flag bit indices (FLG_ZERO=0, FLG_CARRY=1, FLG_NEG=2, FLG_OVF=3).
  - Source ID constants SRC0=1'b0, SRC1=1'b1.
- Sub-module alu_rr_pick:
  - 2-way combinational round-robin picker.
  - Inputs: valids, last_grant, enable (can_accept).
  - Output: one-hot grant.
  - Carries the ALU_ARB_FIXED_PRIO_EN variant.
- ALU instantiated outside this block and connected through the alu_* ports.

Test Plan:
- Single op: req0 a=32'hFFFF_FFFF, b=0, aluc=4'h0, out_ready=1 -> req0_ready=1 same cycle; next cycle out_valid=1, out_src=0, out_r and out_flags match the ALU model for those operands.
- Both valid for 4 cycles, out_ready=1 -> ready pattern req0,req1,req0,req1; out_src sequence 0,1,0,1; one result per cycle. With ALU_ARB_FIXED_PRIO_EN -> all four grants go to req0.
- Backpressure: fill result (a=32'd16, b=32'd2), hold out_ready=0 for 5 cycles with both requests valid -> both ready=0, out_r/out_flags/out_src unchanged; release -> reload in the same cycle, no gap.
- Idle drain: result FULL, out_ready=1, no requests -> out_valid=0 next cycle; alu_a=alu_b=0, alu_aluc=0.
- Async reset mid-stream: assert rst_n=0 between clock edges while FULL -> out_valid=0 immediately; after release, a tie is won by req0.
- aluc sweep 4'h0..4'hF from req1 with a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> 16 results in order, each matching the ALU model, out_src=1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared widths, flag indices, source IDs and state encoding for the ALU arbiter
package alu_arb_pkg;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 4;
  localparam int NFLG   = 4;

  localparam int FLG_ZERO = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_NEG = 2;
  localparam int FLG_OVF = 3;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // The result register's valid bit is the whole state.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_rr_pick.sv
// rtl/alu_rr_pick.sv - 2-way combinational picker; ALU_ARB_FIXED_PRIO_EN selects fixed priority to requester 0
module alu_rr_pick
  import alu_arb_pkg::*;
(
  input  logic [1:0] valid,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic       last_grant,
`endif
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = 2'b01;
`else
        grant = (last_grant == SRC1) ? 2'b01 : 2'b10;
`endif
      end else begin
        grant = valid;
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - two-requester arbiter/sequencer for a shared ALU; ALU_ARB_FIXED_PRIO_EN selects fixed priority
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  input  logic [CW-1:0]   req0_aluc,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  input  logic [CW-1:0]   req1_aluc,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [CW-1:0]   alu_aluc,
  input  logic [DW-1:0]   alu_r,
  input  logic            alu_zero,
  input  logic            alu_carry,
  input  logic            alu_negative,
  input  logic            alu_overflow,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_r,
  output logic [NFLG-1:0] out_flags,
  output logic            out_src
);

  arb_state_e      state_q, state_d;
  logic [DW-1:0]   out_r_q, out_r_d;
  logic [NFLG-1:0] out_flags_q, out_flags_d;
  logic            out_src_q, out_src_d;
  logic [NFLG-1:0] alu_flags;
  logic [1:0]      grant;
  logic            can_accept;
  logic            pick_en;

  assign can_accept = (state_q == ST_EMPTY) | out_ready;
  // Gating with rst_n keeps both readies low for the whole reset window.
  assign pick_en    = can_accept & rst_n;

`ifdef ALU_ARB_FIXED_PRIO_EN
  alu_rr_pick u_pick (
    .valid  ({req1_valid, req0_valid}),
    .enable (pick_en),
    .grant  (grant)
  );
`else
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[1])      last_grant_d = SRC1;
    else if (grant[0]) last_grant_d = SRC0;
  end

  // Resetting to SRC1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= SRC1;
    else        last_grant_q <= last_grant_d;
  end

  alu_rr_pick u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .enable     (pick_en),
    .grant      (grant)
  );
`endif

  always_comb begin
    alu_flags            = '0;
    alu_flags[FLG_ZERO]  = alu_zero;
    alu_flags[FLG_CARRY] = alu_carry;
    alu_flags[FLG_NEG]   = alu_negative;
    alu_flags[FLG_OVF]   = alu_overflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_r_q     <= '0;
      out_flags_q <= '0;
      out_src_q   <= SRC0;
    end else begin
      state_q     <= state_d;
      out_r_q     <= out_r_d;
      out_flags_q <= out_flags_d;
      out_src_q   <= out_src_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    out_r_d     = out_r_q;
    out_flags_d = out_flags_q;
    out_src_d   = out_src_q;
    if (grant != 2'b00) begin
      state_d     = ST_FULL;
      out_r_d     = alu_r;
      out_flags_d = alu_flags;
      out_src_d   = grant[1] ? SRC1 : SRC0;
    end else if (out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Idle bus is driven to zero so the shared ALU never sees stale operands.
  always_comb begin
    req0_ready = grant[0];
    req1_ready = grant[1];
    out_valid  = (state_q == ST_FULL);
    out_r      = out_r_q;
    out_flags  = out_flags_q;
    out_src    = out_src_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_aluc   = '0;
    if (grant[0]) begin
      alu_a    = req0_a;
      alu_b    = req0_b;
      alu_aluc = req0_aluc;
    end else if (grant[1]) begin
      alu_a    = req1_a;
      alu_b    = req1_b;
      alu_aluc = req1_aluc;
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - directed self-checking bench for alu_share_arb with a behavioural ALU
module tb_alu_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_aluc, req1_aluc;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_aluc;
  logic        alu_zero, alu_carry, alu_negative, alu_overflow;
  logic        out_valid, out_ready, out_src;
  logic [31:0] out_r;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arb dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc), .alu_r(alu_r),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_flags(out_flags), .out_src(out_src)
  );

  // External ALU: 0 add,1 sub,2 and,3 or,4 xor,5 nor,6 sll,7 srl,8 sra,9 slt,10 sltu,11 lui, else pass a
  logic [31:0] m_r;
  logic        m_c, m_v;
  always_comb begin
    m_r = alu_a;
    m_c = 1'b0;
    m_v = 1'b0;
    case (alu_aluc)
      4'd0: begin
        {m_c, m_r} = {1'b0, alu_a} + {1'b0, alu_b};
        m_v = (alu_a[31] == alu_b[31]) && (m_r[31] != alu_a[31]);
      end
      4'd1: begin
        m_r = alu_a - alu_b;
        m_c = alu_a < alu_b;
        m_v = (alu_a[31] != alu_b[31]) && (m_r[31] != alu_a[31]);
      end
      4'd2:  m_r = alu_a & alu_b;
      4'd3:  m_r = alu_a | alu_b;
      4'd4:  m_r = alu_a ^ alu_b;
      4'd5:  m_r = ~(alu_a | alu_b);
      4'd6:  m_r = alu_b << alu_a[4:0];
      4'd7:  m_r = alu_b >> alu_a[4:0];
      4'd8:  m_r = $signed(alu_b) >>> alu_a[4:0];
      4'd9:  m_r = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd10: m_r = {31'b0, alu_a < alu_b};
      4'd11: m_r = {alu_b[15:0], 16'h0000};
      default: m_r = alu_a;
    endcase
  end
  assign alu_r        = m_r;
  assign alu_zero     = (m_r == 32'd0);
  assign alu_negative = m_r[31];
  assign alu_carry    = m_c;
  assign alu_overflow = m_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (out_r !== 32'd0) begin errors++; $display("FAIL reset_r got %h want 0", out_r); end
    checks++; if (out_flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %h want 0", out_flags); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL reset_src got %0b want 0", out_src); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {req1_ready, req0_ready}); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_rdy [4];
    logic        exp_src [4];
    logic [31:0] exp_r   [4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_rdy = '{2'b01, 2'b01, 2'b01, 2'b01};
    exp_src = '{1'b0, 1'b0, 1'b0, 1'b0};
    exp_r   = '{32'd3, 32'd3, 32'd3, 32'd3};
`else
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_src = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_r   = '{32'd3, 32'd2, 32'd3, 32'd2};
`endif
    req0_a = 32'd1; req0_b = 32'd2; req0_aluc = 4'd0;
    req1_a = 32'd5; req1_b = 32'd3; req1_aluc = 4'd1;
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({req1_ready, req0_ready} !== exp_rdy[i]) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", i, {req1_ready, req0_ready}, exp_rdy[i]); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %0b want 1", i, out_valid); end
      checks++; if (out_src !== exp_src[i]) begin errors++; $display("FAIL rr_src[%0d] got %0b want %0b", i, out_src, exp_src[i]); end
      checks++; if (out_r !== exp_r[i]) begin errors++; $display("FAIL rr_r[%0d] got %h want %h", i, out_r, exp_r[i]); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_idle_drain();
    @(negedge clk);
    checks++; if ({alu_a, alu_b, alu_aluc} !== 68'd0) begin errors++; $display("FAIL idle_bus got %h/%h/%h want 0", alu_a, alu_b, alu_aluc); end
    checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL idle_ready got %b want 00", {req1_ready, req0_ready}); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b want 0", out_valid); end
  endtask

  task automatic test_single();
    req0_a = 32'hFFFF_FFFF; req0_b = 32'd0; req0_aluc = 4'h0;
    req0_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", {req1_ready, req0_ready}); end
    checks++; if (alu_a !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single_alu_a got %h want ffffffff", alu_a); end
    tick();
    req0_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL single_src got %0b want 0", out_src); end
    checks++; if (out_r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL single_r got %h want ffffffff", out_r); end
    checks++; if (out_flags !== 4'h4) begin errors++; $display("FAIL single_flags got %h want 4", out_flags); end
    tick();
  endtask

  task automatic test_backpressure();
    logic        exp_src;
    logic [31:0] exp_r;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_src = 1'b0; exp_r = 32'd14;
`else
    exp_src = 1'b1; exp_r = 32'd99;
`endif
    req0_a = 32'd16; req0_b = 32'd2; req0_aluc = 4'h0;
    req0_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    req0_a = 32'd7; req0_b = 32'd7;
    req1_a = 32'd100; req1_b = 32'd1; req1_aluc = 4'h1;
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got %b want 00", i, {req1_ready, req0_ready}); end
      tick();
      checks++; if ({out_valid, out_src, out_flags, out_r} !== {1'b1, 1'b0, 4'h0, 32'd18}) begin
        errors++; $display("FAIL bp_hold[%0d] got v%0b s%0b f%h r%h want v1 s0 f0 r00000012", i, out_valid, out_src, out_flags, out_r);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if ((exp_src ? req1_ready : req0_ready) !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want grant to %0b", {req1_ready, req0_ready}, exp_src); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if ({out_valid, out_src, out_r} !== {1'b1, exp_src, exp_r}) begin
      errors++; $display("FAIL bp_reload got v%0b s%0b r%h want v1 s%0b r%h", out_valid, out_src, out_r, exp_src, exp_r);
    end
    tick();
  endtask

  task automatic test_aluc_sweep();
    logic [31:0] exp_r [16];
    logic [3:0]  exp_f [16];
    exp_r = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8000_0000, 32'h1,
              32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    exp_f = '{4'h6, 4'h1, 4'h4, 4'h4, 4'h1, 4'h1, 4'h4, 4'h0,
              4'h4, 4'h1, 4'h1, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4};
    req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF;
    req1_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      req1_aluc = 4'(k);
      @(negedge clk);
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready[%0d] got %0b want 1", k, req1_ready); end
      tick();
      checks++; if ({out_valid, out_src, out_flags, out_r} !== {1'b1, 1'b1, exp_f[k], exp_r[k]}) begin
        errors++; $display("FAIL sweep[%0d] got v%0b s%0b f%h r%h want v1 s1 f%h r%h", k, out_valid, out_src, out_flags, out_r, exp_f[k], exp_r[k]);
      end
    end
    req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    req0_a = 32'd1; req0_b = 32'd2; req0_aluc = 4'h0;
    req0_valid = 1'b1; out_ready = 1'b1;
    tick();
    req0_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_prefill got %0b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %0b want 0", out_valid); end
    checks++; if (out_r !== 32'd0) begin errors++; $display("FAIL ar_r got %h want 0", out_r); end
    tick();
    rst_n = 1'b1;
    req1_a = 32'd9; req1_b = 32'd9; req1_aluc = 4'h0;
    req0_valid = 1'b1; req1_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL ar_tie got %b want 01", {req1_ready, req0_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if ({out_valid, out_src, out_r} !== {1'b1, 1'b0, 32'd3}) begin
      errors++; $display("FAIL ar_result got v%0b s%0b r%h want v1 s0 r00000003", out_valid, out_src, out_r);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_aluc = '0;
    req1_a = '0; req1_b = '0; req1_aluc = '0;
    test_reset();
    test_round_robin();
    test_idle_drain();
    test_single();
    test_backpressure();
    test_aluc_sweep();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
